// File: rtl/fp_mul_seq_ctrl.sv
// fp_mul_seq_ctrl
//   Sequential floating-point multiplier controller. It drives an iterative
//   shift-add mantissa datapath that retires one multiplier bit per clock.
//   Sign, exponent bias, normalization and special operands are handled
//   around that datapath. Rounding truncates, and denormal inputs flush to zero.
//
// Ports
//   clk, rst        clock, async active-high reset
//   in_valid/ready  operand handshake (in_ready only while idle)
//   in_a, in_b      operands {sign, exp, frac}
//   out_valid/ready result handshake (out_valid only in DONE)
//   out_result      product, held while out_ready is low
//   out_overflow    result saturated to infinity
//   out_underflow   result flushed to zero
//   busy            controller not idle
module fp_mul_seq_ctrl #(
    parameter int EXP_WIDTH = 8,
    parameter int MAN_WIDTH = 23
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_a,
    input  logic [EXP_WIDTH+MAN_WIDTH:0]   in_b,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_WIDTH+MAN_WIDTH:0]   out_result,
    output logic                           out_overflow,
    output logic                           out_underflow,
    output logic                           busy
);
    localparam int E   = EXP_WIDTH;
    localparam int M   = MAN_WIDTH;
    localparam int DW  = 1 + E + M;
    localparam int SIG = M + 1;
    localparam int PW  = 2 * SIG;
    localparam int CW  = $clog2(SIG + 1);
    localparam int EW  = E + 2;

    localparam logic [E-1:0]  EXP_ONES = {E{1'b1}};
    localparam logic [EW-1:0] BIAS     = EW'((2 ** (E - 1)) - 1);
    localparam logic [DW-1:0] QNAN     = {1'b0, EXP_ONES, M'(1 << (M - 1))};

    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [SIG-1:0]  mcand_q, mcand_d;
    logic [SIG-1:0]  mplr_q, mplr_d;
    logic            sign_q, sign_d;
    logic [EW-1:0]   exp_q, exp_d;     // two's complement, biased sum
    logic [DW-1:0]   res_q, res_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;

    // Operand field decode, used only at the capture edge
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic         sgn_in, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign ea     = in_a[DW-2:M];
    assign eb     = in_b[DW-2:M];
    assign fa     = in_a[M-1:0];
    assign fb     = in_b[M-1:0];
    assign sgn_in = in_a[DW-1] ^ in_b[DW-1];
    assign a_nan  = (ea == EXP_ONES) && (fa != '0);
    assign b_nan  = (eb == EXP_ONES) && (fb != '0);
    assign a_inf  = (ea == EXP_ONES) && (fa == '0);
    assign b_inf  = (eb == EXP_ONES) && (fb == '0);
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    // Shift-add step: the carry out of the upper-half add becomes the new MSB
    // as the product shifts right.
    logic [SIG:0] sum;
    assign sum = {1'b0, prod_q[PW-1:SIG]} + (mplr_q[0] ? {1'b0, mcand_q} : '0);

    // Normalization: a set top bit means the significand product is in [2,4)
    logic [EW-1:0] exp_adj;
    logic [M-1:0]  norm_frac;
    logic          norm_ovf, norm_unf;

    assign exp_adj   = exp_q + EW'(prod_q[PW-1]);
    assign norm_frac = prod_q[PW-1] ? prod_q[PW-2 -: M] : prod_q[PW-3 -: M];
    assign norm_ovf  = !exp_adj[EW-1] && (exp_adj[EW-2:0] >= {1'b0, EXP_ONES});
    assign norm_unf  = exp_adj[EW-1] || (exp_adj == '0);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prod_q  <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        mcand_d = mcand_q;
        mplr_d  = mplr_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        res_d   = res_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sign_d  = sgn_in;
                    mcand_d = {1'b1, fa};
                    mplr_d  = {1'b1, fb};
                    exp_d   = {2'b00, ea} + {2'b00, eb} - BIAS;
                    prod_d  = '0;
                    cnt_d   = CW'(SIG);
                    state_d = DONE;
                    if (a_nan || b_nan)
                        res_d = QNAN;
                    else if ((a_inf && b_zero) || (b_inf && a_zero))
                        res_d = QNAN;
                    else if (a_inf || b_inf)
                        res_d = {sgn_in, EXP_ONES, {M{1'b0}}};
                    else if (a_zero || b_zero)
                        res_d = {sgn_in, {(DW-1){1'b0}}};
                    else
                        state_d = MUL;
                end
            end
            MUL: begin
                prod_d = {sum, prod_q[SIG-1:1]};
                mplr_d = mplr_q >> 1;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1))
                    state_d = NORM;
            end
            NORM: begin
                state_d = DONE;
                if (norm_ovf) begin
                    res_d = {sign_q, EXP_ONES, {M{1'b0}}};
                    ovf_d = 1'b1;
                end else if (norm_unf) begin
                    res_d = {sign_q, {(DW-1){1'b0}}};
                    unf_d = 1'b1;
                end else begin
                    res_d = {sign_q, exp_adj[E-1:0], norm_frac};
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        in_ready      = (state_q == IDLE);
        out_valid     = (state_q == DONE);
        busy          = (state_q != IDLE);
        out_result    = res_q;
        out_overflow  = ovf_q;
        out_underflow = unf_q;
    end

endmodule

// File: tb/tb_fp_mul_seq_ctrl.sv
// Self-checking bench for fp_mul_seq_ctrl: directed vectors plus random
// operands, checked against a plain-arithmetic reference model.
module tb_fp_mul_seq_ctrl;
    localparam int E = 8;
    localparam int M = 23;
    localparam int LAT = M + 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic        out_overflow, out_underflow, busy;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fp_mul_seq_ctrl #(.EXP_WIDTH(E), .MAN_WIDTH(M)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result),
        .out_overflow(out_overflow), .out_underflow(out_underflow),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: IEEE-like single multiply, truncating, denormals flushed.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ovf,
                                  output logic unf, output logic spec);
        int          ea, eb, e;
        logic [22:0] fa, fb, fr;
        logic        s;
        logic [63:0] p;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = a[22:0];        fb = b[22:0];
        s  = a[31] ^ b[31];
        ovf = 1'b0; unf = 1'b0; spec = 1'b1;
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0))
            r = 32'h7FC00000;
        else if ((ea == 255 && eb == 0) || (eb == 255 && ea == 0))
            r = 32'h7FC00000;
        else if (ea == 255 || eb == 255)
            r = {s, 8'hFF, 23'h0};
        else if (ea == 0 || eb == 0)
            r = {s, 31'h0};
        else begin
            spec = 1'b0;
            p = 64'({1'b1, fa}) * 64'({1'b1, fb});
            e = ea + eb - 127;
            if (p[47]) begin e++; fr = p[46:24]; end
            else       fr = p[45:23];
            if (e >= 255)     begin r = {s, 8'hFF, 23'h0}; ovf = 1'b1; end
            else if (e <= 0)  begin r = {s, 31'h0};        unf = 1'b1; end
            else              r = {s, e[7:0], fr};
        end
    endfunction

    // One full transaction; 'hold' cycles of backpressure in DONE while
    // junk operands are offered.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input int hold);
        logic [31:0] er;
        logic        eo, eu, es;
        int          n;
        model(a, b, er, eo, eu, es);
        n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_a = a; in_b = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
        n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        chk({tag, ".latency"}, 32'(n), es ? 32'd0 : 32'(LAT));
        chk({tag, ".result"}, out_result, er);
        chk({tag, ".ovf"}, 32'(out_overflow), 32'(eo));
        chk({tag, ".unf"}, 32'(out_underflow), 32'(eu));
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
            @(posedge clk); #1;
            chk({tag, ".hold_result"}, out_result, er);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_result"}, out_result, 32'd0);
        chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.result", out_result, 32'd0);
        chk("reset.flags", {30'd0, out_overflow, out_underflow}, 32'd0);
        #20; @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        run_op("mul_1p5x2",    32'h3FC00000, 32'h40000000, 0);
        run_op("mul_1p5x1p5",  32'h3FC00000, 32'h3FC00000, 0);
        run_op("trunc",        32'h3F800001, 32'h3F800001, 0);
        run_op("overflow",     32'h7F000000, 32'h7F000000, 0);
        run_op("underflow",    32'h00800000, 32'h00800000, 0);
        run_op("sign",         32'hBFC00000, 32'h40000000, 0);
        run_op("inf_x_zero",   32'h7F800000, 32'h00000000, 0);
        run_op("denormal",     32'h00000123, 32'h40000000, 0);
        run_op("neg_inf",      32'hFF800000, 32'h40000000, 0);
        run_op("nan_in",       32'h40000000, 32'h7F812345, 0);
        run_op("backpressure", 32'h3FC00000, 32'h40000000, 5);
        run_op("after_bp",     32'hC0400000, 32'h3FC00000, 0);

        // Reset mid-MUL aborts the operation
        in_a = 32'h3FC00000; in_b = 32'h40000000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst.busy", 32'(busy), 32'd0);
        chk("midrst.in_ready", 32'(in_ready), 32'd1);
        chk("midrst.out_valid", 32'(out_valid), 32'd0);
        chk("midrst.result", out_result, 32'd0);
        chk("midrst.flags", {30'd0, out_overflow, out_underflow}, 32'd0);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("midrst.no_spurious_valid", 32'(seen), 32'd0);
        chk("midrst.in_ready_after", 32'(in_ready), 32'd1);
        run_op("after_rst", 32'h3FC00000, 32'h40000000, 0);

        // Random operands, mostly with in-range exponents
        for (int k = 0; k < 20; k++) begin
            ra = $urandom; rb = $urandom;
            if (k % 4 != 0) begin
                ra[30:23] = 8'($urandom_range(60, 190));
                rb[30:23] = 8'($urandom_range(60, 190));
            end
            run_op($sformatf("rand%0d", k), ra, rb, k % 3);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fp_mul_seq_ctrl.md
Name: fp_mul_seq_ctrl

Overview:
- Sequential single-precision floating-point multiply controller with a valid/ready handshake on both sides.
- It drives one iterative shift-add mantissa datapath that retires one multiplier bit per clock. It also handles sign, exponent bias, normalization and special operands around that datapath.
- It sits between the operand-issue logic and the result writeback, as the area-saving alternative to the combinational mantissa multiplier.
- Rounding is toward zero (truncation). Denormal inputs are flushed to zero.

Parameters:
- EXP_WIDTH, 8, exponent field width; bias = 2^(EXP_WIDTH-1)-1.
- MAN_WIDTH, 23, stored fraction width; significand is MAN_WIDTH+1 bits with the hidden 1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_a  input  1+EXP_WIDTH+MAN_WIDTH  operand A, fields {sign, exp, frac}.
- in_b  input  1+EXP_WIDTH+MAN_WIDTH  operand B, same format.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  1+EXP_WIDTH+MAN_WIDTH  product.
- out_overflow  output  1  result saturated to infinity.
- out_underflow  output  1  result flushed to zero.
- busy  output  1  state != IDLE.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, iteration counter=0, product register=0. All outputs 0 except in_ready=1.
- States: IDLE, MUL, NORM, DONE. in_ready=1 only in IDLE; out_valid=1 only in DONE.
- IDLE: on in_valid & in_ready at edge t, latch sign = sa^sb and both significands {1,frac}. Latch exponent sum = ea+eb-bias, signed, EXP_WIDTH+2 bits.
- Special operand detection at capture, evaluated in priority order:
  1. Any exp=all-ones with frac!=0 (NaN) -> canonical NaN {0, all-ones, 1<<(MAN_WIDTH-1)}.
  2. Inf x zero -> canonical NaN.
  3. Any inf -> {sign, all-ones, 0}.
  4. Any exp=0 -> {sign, 0, 0}.
  - All special cases go directly to DONE at edge t with no flags set.
  - Otherwise go to MUL with counter=MAN_WIDTH+1 and product=0.
- MUL: each cycle, if the current multiplier LSB is 1, add the multiplicand to the upper half of the 2*(MAN_WIDTH+1)-bit product. Then shift the product/multiplier right by 1 and decrement the counter. When the counter reaches 0 (edge t+MAN_WIDTH+1), go to NORM.
- NORM, one cycle, executed at edge t+MAN_WIDTH+2, with P the product of width W=2*MAN_WIDTH+2:
  - If P[W-1]=1: frac = P[W-2 -: MAN_WIDTH] and exp+1.
  - Else: frac = P[W-3 -: MAN_WIDTH].
  - Lower bits are discarded (truncation).
  - Adjusted exp >= all-ones -> {sign, all-ones, 0}, out_overflow=1.
  - Adjusted exp <= 0 -> {sign, 0, 0}, out_underflow=1.
  - Then go to DONE.
- Latency: normal operands give out_valid high from edge t+MAN_WIDTH+2, which is 25 cycles at default. Special operands give out_valid at edge t, i.e. visible the cycle after the accept.
- DONE: out_result and flags are held stable while out_ready=0. On out_valid & out_ready, go to IDLE; out_valid, flags and out_result clear to 0.
- No same-cycle re-accept: in_ready rises the cycle after the output handshake. Minimum issue interval is MAN_WIDTH+3 cycles for normal operands.
- in_a/in_b changes outside the accept edge have no effect. in_valid while busy is ignored and not queued.
- Reset asserted mid-MUL or mid-DONE aborts the operation; the pending result is lost and no out_valid is produced.

Test Plan:
- 0x3FC00000 x 0x40000000 (1.5x2.0) -> out_result=0x40400000, flags 0, out_valid exactly 25 cycles after the accept edge.
- 0x3FC00000 x 0x3FC00000 (1.5x1.5, carry normalization) -> 0x40100000. Also 0x3F800001 x 0x3F800001 -> 0x3F800002 (truncation, no round-up).
- 0x7F000000 x 0x7F000000 -> 0x7F800000, out_overflow=1. Then 0x00800000 x 0x00800000 -> 0x00000000, out_underflow=1. Sign check: 0xBFC00000 x 0x40000000 -> 0xC0400000.
- 0x7F800000 x 0x00000000 -> 0x7FC00000 one cycle after accept. 0x00000123 x 0x40000000 -> 0x00000000 (denormal flushed). 0xFF800000 x 0x40000000 -> 0xFF800000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_result stable, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle and the next operand pair is accepted correctly.
- Assert rst at cycle 10 of MUL -> all outputs 0 asynchronously, in_ready=1 after release, no spurious out_valid. A fresh 1.5x2.0 then completes correctly.
